twiddle_mul8: RTL and testbench

Pipelined, parametrised twiddle-factor multiplier for the 8-point FFT datapath: multiplies a complex sample by any W8^k (k = 0..7), forward or inverse, with rounding and saturation. It generalises the fixed ±0.7071 butterfly rotation to all eight twiddles, adds data width and coefficient-precision parameters, and adds a valid/ready stream interface with backpressure. It sits between butterfly stages on the complex sample stream.

---
 rtl/twiddle_mul8.sv | 166 ++++++++++++++++
 tb/tb_twiddle_mul8.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/twiddle_mul8.sv
// twiddle_mul8: three-stage complex multiply by W8^ke (forward or conjugate),
// with half-up rounding, saturation and a valid/ready stream interface.
// A single stall enable freezes all stages while the output is held.
module twiddle_mul8 #(
    parameter int unsigned DW     = 16,
    parameter int unsigned COEF_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_re,
    input  logic [DW-1:0] in_im,
    input  logic [2:0]    k,
    input  logic          inv,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_re,
    output logic [DW-1:0] out_im,
    output logic          out_sat
);

    // Pre-value, product and shift widths.
    localparam int unsigned PRE_W = DW + 1;
    localparam int unsigned PW    = DW + COEF_W + 1;
    localparam int unsigned SH    = COEF_W - 1;

    // R = round(0.70710678 * 2^(COEF_W-1)), evaluated in fixed point.
    localparam longint unsigned R_NUM = 64'd70710678 << (COEF_W - 1);
    localparam int unsigned     R_VAL = 32'((R_NUM + 64'd50000000) / 64'd100000000);

    localparam logic signed [PW-1:0] RC   = PW'(R_VAL);
    localparam logic signed [PW-1:0] UC   = PW'(64'd1 << SH);
    localparam logic signed [PW-1:0] HALF = PW'(64'd1 << (COEF_W - 2));
    localparam logic signed [PW-1:0] MAXV = PW'((64'd1 << (DW - 1)) - 64'd1);
    localparam logic signed [PW-1:0] MINV = ~MAXV;

    // Scale a pre-value by R (odd index) or unity (even index). The sign is
    // applied after the multiply so that -(xr+xi) with both inputs at the
    // most negative value is still represented exactly.
    function automatic logic signed [PW-1:0] scale(
        input logic signed [PRE_W-1:0] p,
        input logic                    neg,
        input logic                    odd
    );
        logic signed [PW-1:0] m;
        m = PW'(p) * (odd ? RC : UC);
        return neg ? -m : m;
    endfunction

    // Round half up, drop the fraction and clip to DW bits; MSB is the clip flag.
    function automatic logic [DW:0] round_sat(input logic signed [PW-1:0] p);
        logic signed [PW-1:0] t;
        t = (p + HALF) >>> SH;
        if (t > MAXV) begin
            return {1'b1, MAXV[DW-1:0]};
        end else if (t < MINV) begin
            return {1'b1, MINV[DW-1:0]};
        end else begin
            return {1'b0, t[DW-1:0]};
        end
    endfunction

    logic stall;
    logic [2:0] ke_c;

    // Stage 1 registers.
    logic                 s1_valid;
    logic signed [DW-1:0] s1_xr;
    logic signed [DW-1:0] s1_xi;
    logic [2:0]           s1_ke;

    // Stage 1 combinational pre-values.
    logic signed [PRE_W-1:0] xr_e, xi_e, sum_e, dif_e;
    logic signed [PRE_W-1:0] pre_a, pre_b;
    logic                    neg_a, neg_b;

    // Stage 2 registers.
    logic                 s2_valid;
    logic signed [PW-1:0] s2_a;
    logic signed [PW-1:0] s2_b;

    // Stage 3 combinational results.
    logic [DW:0] rs_a, rs_b;

    // Hold the whole pipe whenever the output is offered but not taken.
    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    // Inverse direction uses the conjugate twiddle: index (8-k) mod 8.
    assign ke_c = inv ? 3'(3'd0 - k) : k;

    // Stage 1: capture the sample and its effective twiddle index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_xr    <= '0;
            s1_xi    <= '0;
            s1_ke    <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_xr <= $signed(in_re);
                s1_xi <= $signed(in_im);
                s1_ke <= ke_c;
            end
        end
    end

    // Select the real/imag pre-values and their post-multiply signs.
    always_comb begin
        xr_e  = PRE_W'(s1_xr);
        xi_e  = PRE_W'(s1_xi);
        sum_e = xr_e + xi_e;
        dif_e = xi_e - xr_e;
        pre_a = xr_e;
        neg_a = 1'b0;
        pre_b = xi_e;
        neg_b = 1'b0;
        unique case (s1_ke)
            3'd0: begin pre_a = xr_e;  neg_a = 1'b0; pre_b = xi_e;  neg_b = 1'b0; end
            3'd1: begin pre_a = sum_e; neg_a = 1'b0; pre_b = dif_e; neg_b = 1'b0; end
            3'd2: begin pre_a = xi_e;  neg_a = 1'b0; pre_b = xr_e;  neg_b = 1'b1; end
            3'd3: begin pre_a = dif_e; neg_a = 1'b0; pre_b = sum_e; neg_b = 1'b1; end
            3'd4: begin pre_a = xr_e;  neg_a = 1'b1; pre_b = xi_e;  neg_b = 1'b1; end
            3'd5: begin pre_a = sum_e; neg_a = 1'b1; pre_b = dif_e; neg_b = 1'b1; end
            3'd6: begin pre_a = xi_e;  neg_a = 1'b1; pre_b = xr_e;  neg_b = 1'b0; end
            3'd7: begin pre_a = dif_e; neg_a = 1'b1; pre_b = sum_e; neg_b = 1'b0; end
        endcase
    end

    // Stage 2: register the scaled products.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid <= 1'b0;
            s2_a     <= '0;
            s2_b     <= '0;
        end else if (!stall) begin
            s2_valid <= s1_valid;
            s2_a     <= scale(pre_a, neg_a, s1_ke[0]);
            s2_b     <= scale(pre_b, neg_b, s1_ke[0]);
        end
    end

    // Rounding and saturation of both components.
    always_comb begin
        rs_a = round_sat(s2_a);
        rs_b = round_sat(s2_b);
    end

    // Stage 3: registered outputs, held while stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
            out_sat   <= 1'b0;
        end else if (!stall) begin
            out_valid <= s2_valid;
            out_re    <= rs_a[DW-1:0];
            out_im    <= rs_b[DW-1:0];
            out_sat   <= s2_valid && (rs_a[DW] || rs_b[DW]);
        end
    end

endmodule

// File: tb/tb_twiddle_mul8.sv
// Scoreboard bench for twiddle_mul8 at DW = COEF_W = 16.
module tb_twiddle_mul8;

    typedef struct {
        logic [15:0] re;
        logic [15:0] im;
        logic        sat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_re;
    logic [15:0] in_im;
    logic [2:0]  k;
    logic        inv;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_re;
    logic [15:0] out_im;
    logic        out_sat;

    int n_cmp = 0;
    int n_err = 0;
    exp_t sb[$];

    int run_len = 0;
    int max_run = 0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_re, prev_im;
    logic        prev_sat;

    twiddle_mul8 #(.DW(16), .COEF_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .k         (k),
        .inv       (inv),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: twiddle table from the datasheet, evaluated with wide integers.
    function automatic exp_t model(input int xr, input int xi, input int kk, input int iv);
        int     ke;
        longint a, b, c, ra, rb;
        exp_t   e;
        ke = (iv != 0) ? ((8 - kk) % 8) : kk;
        a = 0;
        b = 0;
        case (ke)
            0: begin a = xr;         b = xi;          end
            1: begin a = xr + xi;    b = xi - xr;     end
            2: begin a = xi;         b = -xr;         end
            3: begin a = xi - xr;    b = -(xr + xi);  end
            4: begin a = -xr;        b = -xi;         end
            5: begin a = -(xr + xi); b = xr - xi;     end
            6: begin a = -xi;        b = xr;          end
            default: begin a = xr - xi; b = xr + xi;  end
        endcase
        c  = (ke % 2 == 1) ? 64'sd23170 : 64'sd32768;
        ra = (a * c + 64'sd16384) >>> 15;
        rb = (b * c + 64'sd16384) >>> 15;
        e.sat = 1'b0;
        if (ra > 32767)  begin ra = 32767;  e.sat = 1'b1; end
        if (ra < -32768) begin ra = -32768; e.sat = 1'b1; end
        if (rb > 32767)  begin rb = 32767;  e.sat = 1'b1; end
        if (rb < -32768) begin rb = -32768; e.sat = 1'b1; end
        e.re = 16'(ra);
        e.im = 16'(rb);
        return e;
    endfunction

    function automatic exp_t mk(input int re, input int im, input logic sat);
        exp_t e;
        e.re  = 16'(re);
        e.im  = 16'(im);
        e.sat = sat;
        return e;
    endfunction

    // Offer one sample; push its expectation once it is accepted.
    task automatic send(input int xr, input int xi, input int kk, input int iv, input exp_t e);
        logic acc;
        in_re    = 16'(xr);
        in_im    = 16'(xi);
        k        = 3'(kk);
        inv      = 1'(iv);
        in_valid = 1'b1;
        acc      = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (acc) sb.push_back(e);
        chk("accept", 32'(acc), 32'd1);
    endtask

    // Send into an idle pipe and measure edges from acceptance to out_valid.
    task automatic send_lat(input int xr, input int xi, input int kk, input int iv, input exp_t e);
        int cyc;
        send(xr, xi, kk, iv, e);
        cyc = 1;
        while (!out_valid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("latency", 32'(cyc), 32'd3);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
        end
        #1;
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    // Output monitor: scoreboard pop on transfer, stall stability, run length.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            prev_stall = 1'b0;
            run_len    = 0;
        end else begin
            if (prev_stall) begin
                chk("hold_re", 32'(out_re), 32'(prev_re));
                chk("hold_im", 32'(out_im), 32'(prev_im));
                chk("hold_sat", 32'(out_sat), 32'(prev_sat));
            end
            if (out_valid && !out_ready) chk("stall_in_ready", 32'(in_ready), 32'd0);
            if (out_valid && out_ready) begin
                n_cmp++;
                assert (sb.size() != 0) else begin
                    n_err++;
                    $error("FAIL unexpected_output: observed re=%0h im=%0h expected none", out_re, out_im);
                end
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("out_re", 32'(out_re), 32'(e.re));
                    chk("out_im", 32'(out_im), 32'(e.im));
                    chk("out_sat", 32'(out_sat), 32'(e.sat));
                end
                run_len++;
                if (run_len > max_run) max_run = run_len;
            end else begin
                run_len = 0;
            end
            prev_stall = out_valid && !out_ready;
            prev_re    = out_re;
            prev_im    = out_im;
            prev_sat   = out_sat;
        end
    end

    initial begin
        int xr, xi;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_re     = '0;
        in_im     = '0;
        k         = '0;
        inv       = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_re", 32'(out_re), 32'd0);
        chk("rst_out_im", 32'(out_im), 32'd0);
        chk("rst_out_sat", 32'(out_sat), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Directed twiddle vectors with hand-derived results.
        send_lat(1000, 0, 1, 0, mk(707, -707, 1'b0));
        wait_drain();
        send(1000, 0, 1, 1, mk(707, 707, 1'b0));
        send(1000, 0, 2, 0, mk(0, -1000, 1'b0));
        send(1000, 0, 0, 0, mk(1000, 0, 1'b0));
        send(-32768, -32768, 1, 0, mk(-32768, 0, 1'b1));
        send(-32768, 5, 4, 0, mk(32767, -5, 1'b1));
        send(-32768, -32768, 5, 1, mk(0, 32767, 1'b1));
        send(-32768, 0, 6, 0, mk(0, -32768, 1'b0));
        wait_drain();

        // Eight back-to-back samples across all twiddles.
        max_run = 0;
        for (int i = 0; i < 8; i++) send(1234, -567, i, 0, model(1234, -567, i, 0));
        wait_drain();
        chk("stream_run", 32'(max_run), 32'd8);

        // Backpressure for 5 cycles with a sample waiting at the input.
        for (int i = 0; i < 3; i++) send(300 * i - 2000, 1500 - 700 * i, i + 3, 1, model(300 * i - 2000, 1500 - 700 * i, i + 3, 1));
        out_ready = 1'b0;
        fork
            send(-12345, 23456, 7, 0, model(-12345, 23456, 7, 0));
            begin
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        send(32767, 32767, 1, 0, model(32767, 32767, 1, 0));
        wait_drain();

        // Random samples, twiddles and directions.
        for (int i = 0; i < 24; i++) begin
            int kk, iv;
            xr = int'($urandom_range(0, 65535)) - 32768;
            xi = int'($urandom_range(0, 65535)) - 32768;
            kk = int'($urandom_range(0, 7));
            iv = int'($urandom_range(0, 1));
            send(xr, xi, kk, iv, model(xr, xi, kk, iv));
        end
        wait_drain();

        // Reset with samples in flight, then a fresh sample.
        for (int i = 0; i < 3; i++) send(100 + i, -50 * i, 2 * i + 1, 0, model(100 + i, -50 * i, 2 * i + 1, 0));
        rst = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out_re", 32'(out_re), 32'd0);
        chk("mid_rst_out_im", 32'(out_im), 32'd0);
        chk("mid_rst_out_sat", 32'(out_sat), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);
        send_lat(-1000, 2000, 3, 0, model(-1000, 2000, 3, 0));
        wait_drain();
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
